// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS main control unit:
// state encoding, opcode and ALU-op codes, and the decoded control bundle.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_ERR    = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] ALUOP_RTYPE = 4'b0000;
  localparam logic [3:0] ALUOP_ADD   = 4'b0010;
  localparam logic [3:0] ALUOP_BEQ   = 4'b0100;
  localparam logic [3:0] ALUOP_BNE   = 4'b0101;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [3:0] alu_op;
  } ctrl_out_t;

  // Immediate ALU ops pass opcode[3:0] straight through as their ALU-op code.
  function automatic logic is_imm_alu(input logic [5:0] op);
    case (op)
      OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_out_dec.sv
// Combinational decoder from registered state (plus opcode and mem_ready)
// to the datapath control bundle.
module ctrl_out_dec
  import ctrl_pkg::*;
(
  input  state_e      state,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output ctrl_out_t   ctl
);

  always_comb begin
    ctl        = '0;
    ctl.alu_op = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = 2'b01;
        ctl.pc_src    = 2'b00;
        ctl.ir_write  = mem_ready;
        ctl.pc_write  = mem_ready;
      end
      S_DECODE: ctl.alu_src_b = 2'b11;
      S_MEMADR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        ctl.mem_read = 1'b1;
        ctl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctl.mem_write = 1'b1;
        ctl.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = ALUOP_RTYPE;
      end
      S_ALUWB: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
      end
      S_IEXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        ctl.alu_op    = opcode[3:0];
      end
      S_IWB: ctl.reg_write = 1'b1;
      S_BRANCH: begin
        ctl.alu_src_a = 1'b1;
        ctl.pc_src    = 2'b01;
        if (opcode == OP_BNE) begin
          ctl.alu_op    = ALUOP_BNE;
          ctl.branch_ne = 1'b1;
        end else begin
          ctl.alu_op = ALUOP_BEQ;
          ctl.branch = 1'b1;
        end
      end
      S_JUMP: begin
        ctl.pc_write = 1'b1;
        ctl.pc_src   = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_multiciclo.sv
// Multi-cycle MIPS main control FSM with mem_ready stall and optional wait
// timeout. Define CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes into S_ERR.
//
// state    | meaning
// S_IDLE   | post-reset, all outputs idle
// S_FETCH  | instruction read, PC+4 (waits on mem_ready)
// S_DECODE | register read, branch target into ALUOut
// S_MEMADR | lw/sw address generation
// S_MEMRD  | data read (waits on mem_ready)
// S_MEMWB  | load write-back
// S_MEMWR  | data write (waits on mem_ready)
// S_EXEC   | R-type execute
// S_ALUWB  | R-type write-back to rd
// S_IEXEC  | immediate ALU execute
// S_IWB    | immediate write-back to rt
// S_BRANCH | beq/bne compare and conditional PC load
// S_JUMP   | jump target PC load
// S_ERR    | illegal opcode or wait timeout, held until reset
module ctrl_multiciclo
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       branch,
  output logic       branch_ne,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [3:0] alu_op,
  output logic       illegal,
  output logic [3:0] state_o
);

  localparam int CW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;

  state_e      state;
  logic        illegal_q;
  logic [CW-1:0] stall_cnt;
  logic        stalled;
  logic        timeout;
  ctrl_out_t   ctl;

  assign stalled = !mem_ready &&
                   (state == S_FETCH || state == S_MEMRD || state == S_MEMWR);
  assign timeout = (MEM_WAIT_MAX != 0) && stalled &&
                   (stall_cnt == CW'(MEM_WAIT_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      illegal_q <= 1'b0;
      stall_cnt <= '0;
    end else if (timeout) begin
      state     <= S_ERR;
      illegal_q <= 1'b1;
      stall_cnt <= '0;
    end else begin
      // Counter only advances while holding in a wait state, so any state
      // change (always a non-stalled cycle) clears it for the next entry.
      if (stalled && MEM_WAIT_MAX != 0) stall_cnt <= stall_cnt + 1'b1;
      else                              stall_cnt <= '0;
      case (state)
        S_IDLE:   state <= S_FETCH;
        S_FETCH:  if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          if (opcode == OP_LW || opcode == OP_SW)      state <= S_MEMADR;
          else if (opcode == OP_RTYPE)                 state <= S_EXEC;
          else if (opcode == OP_BEQ || opcode == OP_BNE) state <= S_BRANCH;
          else if (is_imm_alu(opcode))                 state <= S_IEXEC;
          else if (opcode == OP_J)                     state <= S_JUMP;
          else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            state     <= S_ERR;
            illegal_q <= 1'b1;
`else
            state <= S_FETCH;
`endif
          end
        end
        S_MEMADR: state <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWB:  state <= S_FETCH;
        S_MEMWR:  if (mem_ready) state <= S_FETCH;
        S_EXEC:   state <= S_ALUWB;
        S_ALUWB:  state <= S_FETCH;
        S_IEXEC:  state <= S_IWB;
        S_IWB:    state <= S_FETCH;
        S_BRANCH: state <= S_FETCH;
        S_JUMP:   state <= S_FETCH;
        S_ERR:    state <= S_ERR;
        default:  state <= S_ERR;
      endcase
    end
  end

  ctrl_out_dec u_out_dec (
    .state     (state),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .ctl       (ctl)
  );

  assign pc_write   = ctl.pc_write;
  assign branch     = ctl.branch;
  assign branch_ne  = ctl.branch_ne;
  assign i_or_d     = ctl.i_or_d;
  assign mem_read   = ctl.mem_read;
  assign mem_write  = ctl.mem_write;
  assign ir_write   = ctl.ir_write;
  assign reg_dst    = ctl.reg_dst;
  assign mem_to_reg = ctl.mem_to_reg;
  assign reg_write  = ctl.reg_write;
  assign alu_src_a  = ctl.alu_src_a;
  assign alu_src_b  = ctl.alu_src_b;
  assign pc_src     = ctl.pc_src;
  assign alu_op     = ctl.alu_op;
  assign illegal    = illegal_q;
  assign state_o    = state;

endmodule

// File: tb/tb_ctrl_multiciclo.sv
// Directed bench for ctrl_multiciclo; expected values are hand-derived.
// Honours CTRL_ILLEGAL_TRAP_EN for the illegal-opcode section.
module tb_ctrl_multiciclo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, branch, branch_ne, i_or_d, mem_read, mem_write;
  logic       ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] alu_op, state_o;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_FETCH  = 4'd1;
  localparam logic [3:0] ST_DECODE = 4'd2;
  localparam logic [3:0] ST_MEMADR = 4'd3;
  localparam logic [3:0] ST_MEMRD  = 4'd4;
  localparam logic [3:0] ST_MEMWB  = 4'd5;
  localparam logic [3:0] ST_MEMWR  = 4'd6;
  localparam logic [3:0] ST_EXEC   = 4'd7;
  localparam logic [3:0] ST_ALUWB  = 4'd8;
  localparam logic [3:0] ST_IEXEC  = 4'd9;
  localparam logic [3:0] ST_IWB    = 4'd10;
  localparam logic [3:0] ST_BRANCH = 4'd11;
  localparam logic [3:0] ST_JUMP   = 4'd12;
  localparam logic [3:0] ST_ERR    = 4'd13;

  ctrl_multiciclo dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .branch     (branch),
    .branch_ne  (branch_ne),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .alu_op     (alu_op),
    .illegal    (illegal),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {pc_write, branch, branch_ne, mem_read, mem_write, ir_write, reg_write}
  function automatic logic [6:0] wen();
    return {pc_write, branch, branch_ne, mem_read, mem_write, ir_write, reg_write};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'b000000;

    tick();
    chk("rst_state", 32'(state_o), 32'(ST_IDLE));
    chk("rst_en",    32'(wen()), 32'h0);
    chk("rst_aluop", 32'(alu_op), 32'h2);
    chk("rst_ill",   32'(illegal), 32'h0);
    rst_n = 1'b1;

    // add: FETCH DECODE EXEC ALUWB
    tick();
    chk("f_state", 32'(state_o), 32'(ST_FETCH));
    chk("f_en",    32'(wen()), 32'b1001010);
    chk("f_srcb",  32'(alu_src_b), 32'h1);
    chk("f_aluop", 32'(alu_op), 32'h2);
    tick();
    chk("add_dec",   32'(state_o), 32'(ST_DECODE));
    chk("dec_srcb",  32'(alu_src_b), 32'h3);
    chk("dec_en",    32'(wen()), 32'h0);
    tick();
    chk("add_exec",  32'(state_o), 32'(ST_EXEC));
    chk("exec_aluop",32'(alu_op), 32'h0);
    chk("exec_src",  32'({alu_src_a, alu_src_b}), 32'b100);
    tick();
    chk("add_wb",    32'(state_o), 32'(ST_ALUWB));
    chk("add_wb_en", 32'(wen()), 32'b0000001);
    chk("add_regdst",32'(reg_dst), 32'h1);
    opcode = 6'b100011;

    // lw with two stalled MEMRD cycles: 7 cycles total
    tick(); chk("lw_f", 32'(state_o), 32'(ST_FETCH));
    tick(); chk("lw_d", 32'(state_o), 32'(ST_DECODE));
    tick();
    chk("lw_adr",   32'(state_o), 32'(ST_MEMADR));
    chk("lw_aluop", 32'(alu_op), 32'h2);
    chk("lw_srcb",  32'({alu_src_a, alu_src_b}), 32'b110);
    mem_ready = 1'b0;
    tick(); chk("lw_rd1", 32'(state_o), 32'(ST_MEMRD));
    tick();
    chk("lw_rd2",   32'(state_o), 32'(ST_MEMRD));
    chk("lw_rd_en", 32'({mem_read, i_or_d, wen()}), 32'b11_0001000);
    tick();
    chk("lw_rd3",   32'(state_o), 32'(ST_MEMRD));
    mem_ready = 1'b1;
    tick();
    chk("lw_wb",    32'(state_o), 32'(ST_MEMWB));
    chk("lw_m2r",   32'({mem_to_reg, reg_dst, reg_write}), 32'b101);
    opcode = 6'b101011;

    // sw: address uses ADD, then reset is pulsed while mem_write is high
    tick(); chk("sw_f", 32'(state_o), 32'(ST_FETCH));
    tick(); chk("sw_d", 32'(state_o), 32'(ST_DECODE));
    tick();
    chk("sw_adr",   32'(state_o), 32'(ST_MEMADR));
    chk("sw_aluop", 32'(alu_op), 32'h2);
    tick();
    chk("sw_wr",    32'(state_o), 32'(ST_MEMWR));
    chk("sw_wr_en", 32'({i_or_d, wen()}), 32'b1_0000100);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_mw",    32'(mem_write), 32'h0);
    chk("arst_state", 32'(state_o), 32'(ST_IDLE));
    tick();
    rst_n = 1'b1;
    opcode = 6'b000101;

    // bne: 3 cycles
    tick(); chk("bne_f", 32'(state_o), 32'(ST_FETCH));
    tick(); chk("bne_d", 32'(state_o), 32'(ST_DECODE));
    tick();
    chk("bne_br",    32'(state_o), 32'(ST_BRANCH));
    chk("bne_flags", 32'({branch, branch_ne, pc_write}), 32'b010);
    chk("bne_aluop", 32'(alu_op), 32'h5);
    chk("bne_pcsrc", 32'(pc_src), 32'h1);
    tick();
    chk("bne_next",  32'(state_o), 32'(ST_FETCH));
    opcode = 6'b001010;

    // slti
    tick(); chk("slti_d", 32'(state_o), 32'(ST_DECODE));
    tick();
    chk("slti_ex",    32'(state_o), 32'(ST_IEXEC));
    chk("slti_aluop", 32'(alu_op), 32'hA);
    tick();
    chk("slti_wb",    32'(state_o), 32'(ST_IWB));
    chk("slti_wb_en", 32'({reg_dst, wen()}), 32'b0_0000001);
    opcode = 6'b000010;

    // j, then a stalled fetch of an illegal opcode
    tick(); chk("j_f", 32'(state_o), 32'(ST_FETCH));
    tick(); chk("j_d", 32'(state_o), 32'(ST_DECODE));
    tick();
    chk("j_jump",  32'(state_o), 32'(ST_JUMP));
    chk("j_en",    32'(wen()), 32'b1000000);
    chk("j_pcsrc", 32'(pc_src), 32'h2);
    mem_ready = 1'b0;
    opcode = 6'b111111;
    tick();
    chk("fstall_st", 32'(state_o), 32'(ST_FETCH));
    chk("fstall_en", 32'(wen()), 32'b0001000);
    tick();
    chk("fstall_hold", 32'(state_o), 32'(ST_FETCH));
    mem_ready = 1'b1;
    tick(); chk("ill_d", 32'(state_o), 32'(ST_DECODE));
    tick();
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("ill_state", 32'(state_o), 32'(ST_ERR));
    chk("ill_flag",  32'(illegal), 32'h1);
    chk("ill_en",    32'(wen()), 32'h0);
    tick(); tick();
    chk("err_hold",  32'(state_o), 32'(ST_ERR));
    chk("err_en",    32'(wen()), 32'h0);
    chk("ill_stick", 32'(illegal), 32'h1);
    rst_n = 1'b0;
    tick();
    chk("ill_clr",   32'(illegal), 32'h0);
    chk("ill_rst_st",32'(state_o), 32'(ST_IDLE));
    rst_n = 1'b1;
`else
    chk("nop_state", 32'(state_o), 32'(ST_FETCH));
    chk("nop_flag",  32'(illegal), 32'h0);
    tick();
    chk("nop_dec",   32'(state_o), 32'(ST_DECODE));
    chk("nop_flag2", 32'(illegal), 32'h0);
`endif
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
